// File: rtl/thresh_pkg.sv
// Shared types and constants for the threshold reload sequencer.
package thresh_pkg;
  localparam int NBEAMS      = 54;
  localparam int THRESH_BITS = 18;
  localparam int BEAM_BITS   = $clog2(NBEAMS);

  typedef enum logic {
    PATH_REAL = 1'b0,
    PATH_SUB  = 1'b1
  } path_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_UPDATE,
    S_DONE
  } state_e;
endpackage

// File: rtl/thresh_shadow_ram.sv
// Shadow copy of both threshold paths: one write port, one registered read
// port that returns the same beam of both paths.
module thresh_shadow_ram #(
  parameter int                      NBEAMS         = thresh_pkg::NBEAMS,
  parameter int                      THRESH_BITS    = thresh_pkg::THRESH_BITS,
  parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = {THRESH_BITS{1'b1}}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic                        wpath_i,
  input  logic [$clog2(NBEAMS)-1:0]   waddr_i,
  input  logic [THRESH_BITS-1:0]      wdat_i,
  input  logic [$clog2(NBEAMS)-1:0]   raddr_i,
  output logic [2*THRESH_BITS-1:0]    rdat_o
);
  import thresh_pkg::*;

  logic [THRESH_BITS-1:0]   mem_q [2][NBEAMS];
  logic [2*THRESH_BITS-1:0] rdat_q;

  // Write-through so a write and a reload launched on the same edge
  // ship the freshly written value.
  function automatic logic [THRESH_BITS-1:0] rd_word(input path_e p);
    if (we_i && (wpath_i == p) && (waddr_i == raddr_i)) return wdat_i;
    return mem_q[p][raddr_i];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < NBEAMS; b++)
          mem_q[p][b] <= DEFAULT_THRESH;
      rdat_q <= '0;
    end else begin
      if (we_i) mem_q[wpath_i][waddr_i] <= wdat_i;
      rdat_q <= {rd_word(PATH_SUB), rd_word(PATH_REAL)};
    end
  end

  assign rdat_o = rdat_q;
endmodule

// File: rtl/thresh_load_sequencer.sv
// Shifts the shadow thresholds into the beamformer cascade (highest beam
// first), waits SETTLE_CYCLES, then strobes update; one reload may queue.
module thresh_load_sequencer #(
  parameter int                      NBEAMS         = thresh_pkg::NBEAMS,
  parameter int                      THRESH_BITS    = thresh_pkg::THRESH_BITS,
  parameter int                      SETTLE_CYCLES  = 2,
  parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = {THRESH_BITS{1'b1}}
) (
  input  logic                        tclk,
  input  logic                        tclk_resetn,
  input  logic                        cfg_wr_i,
  input  logic                        cfg_path_i,
  input  logic [$clog2(NBEAMS)-1:0]   cfg_beam_i,
  input  logic [THRESH_BITS-1:0]      cfg_dat_i,
  output logic                        cfg_ready_o,
  input  logic                        load_i,
  input  logic [1:0]                  load_sel_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2*THRESH_BITS-1:0]    thresh_o,
  output logic [1:0]                  thresh_wr_o,
  output logic [1:0]                  thresh_update_o
);
  import thresh_pkg::*;

  localparam int              BW          = $clog2(NBEAMS);
  localparam logic [BW-1:0]   K_TOP       = BW'(NBEAMS - 1);
  localparam logic [3:0]      SETTLE_INIT = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_e                   state_q;
  logic [1:0]               sel_q, pend_sel_q;
  logic                     pend_q;
  logic [BW-1:0]            k_q, raddr;
  logic [3:0]               cnt_q;
  logic [2*THRESH_BITS-1:0] thresh_q, rdat;
  logic [1:0]               wr_q, upd_q;
  logic                     done_q, busy_q, ready_q;
  logic                     wr_ok, load_new;
  logic [1:0]               load_sel_m;

  assign wr_ok      = cfg_wr_i && ready_q && ({1'b0, cfg_beam_i} < (BW+1)'(NBEAMS));
  assign load_new   = load_i && (load_sel_i != 2'b00);
  assign load_sel_m = load_new ? load_sel_i : 2'b00;

  // Read one beam ahead: K_TOP is fetched on the edge that enters SHIFT,
  // then k-1 while shifting, so every SHIFT cycle has its word ready.
  assign raddr = (state_q == S_SHIFT && k_q != '0) ? k_q - 1'b1 : K_TOP;

  thresh_shadow_ram #(
    .NBEAMS         (NBEAMS),
    .THRESH_BITS    (THRESH_BITS),
    .DEFAULT_THRESH (DEFAULT_THRESH)
  ) u_ram (
    .clk_i   (tclk),
    .rst_ni  (tclk_resetn),
    .we_i    (wr_ok),
    .wpath_i (cfg_path_i),
    .waddr_i (cfg_beam_i),
    .wdat_i  (cfg_dat_i),
    .raddr_i (raddr),
    .rdat_o  (rdat)
  );

  always_ff @(posedge tclk or negedge tclk_resetn) begin
    if (!tclk_resetn) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      thresh_q   <= '0;
      wr_q       <= '0;
      upd_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      wr_q   <= '0;
      upd_q  <= '0;
      done_q <= 1'b0;
      if (state_q != S_IDLE && load_new) begin
        pend_q     <= 1'b1;
        pend_sel_q <= pend_sel_q | load_sel_i;
      end
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (load_new || pend_q) begin
            state_q    <= S_SHIFT;
            sel_q      <= pend_sel_q | load_sel_m;
            k_q        <= K_TOP;
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
          end
        end
        S_SHIFT: begin
          thresh_q <= rdat;
          wr_q     <= sel_q;
          k_q      <= k_q - 1'b1;
          if (k_q == '0) begin
            cnt_q   <= SETTLE_INIT;
            state_q <= (SETTLE_CYCLES == 0) ? S_UPDATE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_q <= S_UPDATE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_UPDATE: begin
          upd_q   <= sel_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          if (pend_q) begin
            state_q    <= S_SHIFT;
            sel_q      <= pend_sel_q;
            k_q        <= K_TOP;
            pend_q     <= load_new;
            pend_sel_q <= load_sel_m;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready_o     = ready_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign thresh_o        = thresh_q;
  assign thresh_wr_o     = wr_q;
  assign thresh_update_o = upd_q;
endmodule

// File: tb/tb_thresh_load_sequencer.sv
// Scoreboard bench: stimulus pushes expected shift/update/done events with
// their cycle numbers; a negedge monitor pops and compares.
module tb_thresh_load_sequencer;
  localparam int NB = 54;
  localparam int ST = 2;

  logic        tclk = 1'b0, tclk_resetn = 1'b0;
  logic        cfg_wr_i = 1'b0, cfg_path_i = 1'b0;
  logic [5:0]  cfg_beam_i = '0;
  logic [17:0] cfg_dat_i = '0;
  logic        load_i = 1'b0, load2_i = 1'b0;
  logic [1:0]  load_sel_i = '0, load2_sel_i = '0;
  logic        cfg_ready_o, busy_o, done_o;
  logic [35:0] thresh_o;
  logic [1:0]  thresh_wr_o, thresh_update_o;
  logic        z_ready, z_busy, z_done;
  logic [35:0] z_thresh;
  logic [1:0]  z_wr, z_upd;

  thresh_load_sequencer #(.SETTLE_CYCLES(ST)) dut (
    .tclk(tclk), .tclk_resetn(tclk_resetn), .cfg_wr_i(cfg_wr_i), .cfg_path_i(cfg_path_i),
    .cfg_beam_i(cfg_beam_i), .cfg_dat_i(cfg_dat_i), .cfg_ready_o(cfg_ready_o),
    .load_i(load_i), .load_sel_i(load_sel_i), .busy_o(busy_o), .done_o(done_o),
    .thresh_o(thresh_o), .thresh_wr_o(thresh_wr_o), .thresh_update_o(thresh_update_o));

  thresh_load_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .tclk(tclk), .tclk_resetn(tclk_resetn), .cfg_wr_i(cfg_wr_i), .cfg_path_i(cfg_path_i),
    .cfg_beam_i(cfg_beam_i), .cfg_dat_i(cfg_dat_i), .cfg_ready_o(z_ready),
    .load_i(load2_i), .load_sel_i(load2_sel_i), .busy_o(z_busy), .done_o(z_done),
    .thresh_o(z_thresh), .thresh_wr_o(z_wr), .thresh_update_o(z_upd));

  always #5 tclk = ~tclk;

  int cyc = 0;
  always @(posedge tclk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 shift, 1 update, 2 done
    int          cyc;
    logic [1:0]  sel;
    logic [35:0] dat;
  } ev_t;

  ev_t         q[$];
  int          nvec = 0, nerr = 0;
  logic [17:0] m [2][NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int kind, input logic [1:0] sel, input logic [35:0] dat);
    ev_t e;
    nvec++;
    if (q.size() == 0) begin
      nerr++;
      $display("FAIL unexpected event kind %0d at cyc %0d sel %b", kind, cyc, sel);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.sel !== sel || e.dat !== dat) begin
        nerr++;
        $display("FAIL event: got kind %0d cyc %0d sel %b dat %h, want kind %0d cyc %0d sel %b dat %h",
                 kind, cyc, sel, dat, e.kind, e.cyc, e.sel, e.dat);
      end
    end
  endtask

  always @(negedge tclk) begin
    if (tclk_resetn) begin
      if (thresh_wr_o != 2'b00)     pop_chk(0, thresh_wr_o, thresh_o);
      if (thresh_update_o != 2'b00) pop_chk(1, thresh_update_o, '0);
      if (done_o)                   pop_chk(2, 2'b00, '0);
    end
  end

  task automatic push_reload(input int c0, input logic [1:0] sel);
    for (int i = 0; i < NB; i++) begin
      int k = NB - 1 - i;
      q.push_back('{0, c0 + 1 + i, sel, {m[1][k], m[0][k]}});
    end
    q.push_back('{1, c0 + NB + ST + 1, sel, 36'h0});
    q.push_back('{2, c0 + NB + ST + 2, 2'b00, 36'h0});
  endtask

  task automatic tick();
    @(negedge tclk);
  endtask

  task automatic load_raw(input logic [1:0] sel);
    load_i = 1'b1; load_sel_i = sel;
    tick();
    load_i = 1'b0; load_sel_i = 2'b00;
  endtask

  task automatic do_load(input logic [1:0] sel, output int c0);
    c0 = cyc + 1;
    push_reload(c0, sel);
    load_raw(sel);
  endtask

  task automatic cfg_write(input logic p, input int b, input logic [17:0] d, input bit accept);
    cfg_wr_i = 1'b1; cfg_path_i = p; cfg_beam_i = 6'(b); cfg_dat_i = d;
    tick();
    cfg_wr_i = 1'b0;
    if (accept) m[p][b] = d;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin tick(); n++; end
    tick(); tick();
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL %s: %0d expected events never appeared, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++) m[p][b] = 18'h3FFFF;
  endtask

  initial begin
    int c0, d, cu, cd;
    logic [1:0] zsel;
    model_reset();

    #1;
    chk("rst_thresh", thresh_o, 0);
    chk("rst_wr", thresh_wr_o, 0);
    chk("rst_upd", thresh_update_o, 0);
    chk("rst_busy_done", {busy_o, done_o}, 0);
    chk("rst_ready", cfg_ready_o, 0);
    repeat (3) tick();
    tclk_resetn = 1'b1;
    chk("ready_before_edge", cfg_ready_o, 0);
    tick();
    chk("ready_after_release", cfg_ready_o, 1);

    // reset-default reload, both paths
    do_load(2'b11, c0);
    chk("busy_in_reload", busy_o, 1);
    chk("ready_in_reload", cfg_ready_o, 0);
    drain("default_reload");
    chk("idle_after_reload", {busy_o, cfg_ready_o}, 2'b01);

    // ordered shift of path 0
    for (int b = 0; b < NB; b++) cfg_write(1'b0, b, 18'(1000 + b), 1'b1);
    do_load(2'b01, c0);
    drain("ordered_shift");

    // writes while busy are dropped
    do_load(2'b01, c0);
    repeat (5) tick();
    chk("ready_mid_shift", cfg_ready_o, 0);
    cfg_write(1'b0, 5, 18'd777, 1'b0);
    drain("blocked_write_reload");
    do_load(2'b01, c0);
    drain("after_blocked_write");

    // two mid-shift loads coalesce into one queued reload
    do_load(2'b01, c0);
    d = c0 + NB + ST + 2;
    repeat (9) tick();
    push_reload(d, 2'b10);
    load_raw(2'b10);
    repeat (4) tick();
    load_raw(2'b10);
    drain("coalesced_pending");

    // load landing in the DONE cycle is queued
    do_load(2'b01, c0);
    d = c0 + NB + ST + 2;
    while (cyc < d - 1) tick();
    push_reload(d + 1, 2'b10);
    load_raw(2'b10);
    drain("load_in_done");

    // write and load in the same IDLE cycle: reload carries the new value
    m[0][53] = 18'd5;
    c0 = cyc + 1;
    push_reload(c0, 2'b01);
    cfg_wr_i = 1'b1; cfg_path_i = 1'b0; cfg_beam_i = 6'd53; cfg_dat_i = 18'd5;
    load_i = 1'b1; load_sel_i = 2'b01;
    tick();
    cfg_wr_i = 1'b0; load_i = 1'b0; load_sel_i = 2'b00;
    drain("write_with_load");

    // sel 00 ignored
    load_raw(2'b00);
    for (int i = 0; i < 3; i++) begin
      chk("sel00_busy", busy_o, 0);
      tick();
    end

    // out-of-range beam dropped
    cfg_write(1'b1, 54, 18'd123, 1'b0);
    do_load(2'b11, c0);
    drain("beam54_dropped");

    // reset in the middle of a shift
    do_load(2'b11, c0);
    while (cyc < c0 + 20) tick();
    #2 tclk_resetn = 1'b0;
    q.delete();
    #1;
    chk("midrst_wr", thresh_wr_o, 0);
    chk("midrst_upd_busy", {thresh_update_o, busy_o}, 0);
    chk("midrst_thresh", thresh_o, 0);
    repeat (2) tick();
    tclk_resetn = 1'b1;
    model_reset();
    tick();
    do_load(2'b11, c0);
    drain("reload_after_reset");

    // SETTLE_CYCLES = 0 instance timing
    c0 = cyc + 1;
    load2_i = 1'b1; load2_sel_i = 2'b01;
    tick();
    load2_i = 1'b0; load2_sel_i = 2'b00;
    cu = -1; cd = -1; zsel = 2'b00;
    for (int n = 0; n < 100 && cd < 0; n++) begin
      if (z_upd != 2'b00 && cu < 0) begin cu = cyc; zsel = z_upd; end
      if (z_done) cd = cyc;
      tick();
    end
    chk("settle0_update_cycle", 64'(cu - c0), 64'(NB + 1));
    chk("settle0_done_cycle", 64'(cd - c0), 64'(NB + 2));
    chk("settle0_update_sel", zsel, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
